// File: rtl/sr_drv_pkg.sv
// Shared types and S/R encodings for the flop-bank driver.
package sr_drv_pkg;

    typedef enum logic [1:0] {IDLE, DEAD, SETTLE} state_t;

    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_CLR  = 2'b01;
    localparam logic [1:0] SR_DEAD = 2'b00;

    // {s,r} that forces an sr_ff to the given value
    function automatic logic [1:0] encode(input logic b);
        return b ? SR_SET : SR_CLR;
    endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// Target-vector valid/ready handshake into the flop-bank driver.
interface sr_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (output tgt_valid, output tgt_data, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/sr_phase_timer.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module sr_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/sr_bank_driver.sv
// Drives the S/R lines of an sr_ff bank through dead/drive/settle phases
// and reports a per-bit readback error mask on completion.
module sr_bank_driver
    import sr_drv_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEAD_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sr_bank_driver_if.slave  tgt,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q_fb,
    input  logic [WIDTH-1:0] qb_fb,
    output logic [WIDTH-1:0] applied,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] err_mask
);
    localparam int MAXC = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] DEAD_LD   = TW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic             accept, finish;
    logic             tmr_load, tmr_zero;
    logic [TW-1:0]    tmr_ld_val;
    logic [WIDTH-1:0] chg, applied_nxt, dead_mask, s_nxt, r_nxt;

    assign tgt.tgt_ready = (state == IDLE) && !rst;
    assign accept        = tgt.tgt_valid && tgt.tgt_ready;
    assign finish        = (state == SETTLE) && tmr_zero;
    assign busy          = (state != IDLE);

    sr_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_ld_val = '0;
        case (state)
            IDLE: if (accept) begin
                tmr_load = 1'b1;
                if (DEAD_CYCLES > 0) begin
                    state_nxt  = DEAD;
                    tmr_ld_val = DEAD_LD;
                end else begin
                    state_nxt  = SETTLE;
                    tmr_ld_val = SETTLE_LD;
                end
            end
            DEAD: if (tmr_zero) begin
                state_nxt  = SETTLE;
                tmr_load   = 1'b1;
                tmr_ld_val = SETTLE_LD;
            end
            SETTLE: if (tmr_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // S/R are derived from next-cycle state so the registered lines never show 11
    always_comb begin
        applied_nxt = accept ? tgt.tgt_data : applied;
        dead_mask   = '0;
        if (state_nxt == DEAD) dead_mask = accept ? (tgt.tgt_data ^ applied) : chg;
        s_nxt = '0;
        r_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {s_nxt[i], r_nxt[i]} = dead_mask[i] ? SR_DEAD : encode(applied_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            applied  <= '0;
            chg      <= '0;
            s        <= '0;
            r        <= '1;
            done     <= 1'b0;
            err_mask <= '0;
        end else begin
            applied <= applied_nxt;
            if (accept) chg <= tgt.tgt_data ^ applied;
            s    <= s_nxt;
            r    <= r_nxt;
            done <= finish;
            if (finish) err_mask <= (q_fb ^ applied) | (qb_fb ^ ~applied);
        end
    end
endmodule

// File: tb/tb_sr_bank_driver.sv
// Randomized self-checking bench for sr_bank_driver with an sr_ff bank model on feedback.
module tb_sr_bank_driver;
    localparam int W   = 4;
    localparam int D   = 1;
    localparam int S   = 2;
    localparam int LAT = 1 + D + S;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_bank_driver_if #(.WIDTH(W)) tgt();
    logic [W-1:0] s, r, q_fb, qb_fb, applied, err_mask;
    logic         busy, done;

    sr_bank_driver #(.WIDTH(W), .DEAD_CYCLES(D), .SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .tgt      (tgt.slave),
        .s        (s),
        .r        (r),
        .q_fb     (q_fb),
        .qb_fb    (qb_fb),
        .applied  (applied),
        .busy     (busy),
        .done     (done),
        .err_mask (err_mask)
    );

    // sr_ff bank: 10 sets, 01 and 00 clear; selected bits can be forced stuck
    logic [W-1:0] q_m = '0;
    logic [W-1:0] stuck_mask = '0;
    logic [W-1:0] stuck_val = '0;
    always @(posedge clk) q_m <= s & ~r;
    assign q_fb  = (q_m & ~stuck_mask) | (stuck_val & stuck_mask);
    assign qb_fb = ~q_fb;

    int checks = 0;
    int errors = 0;
    int inv_viol = 0;
    logic mon_en = 1'b0;
    always @(negedge clk) if (mon_en && ((s & r) != '0)) inv_viol++;

    logic [W-1:0] cur_app, cur_err;
    logic [W-1:0] o_s [0:6];
    logic [W-1:0] o_r [0:6];
    logic [W-1:0] o_app [0:6];
    logic [W-1:0] o_err [0:6];
    logic         o_rdy [0:6];
    logic         o_done [0:6];
    logic         o_busy [0:6];

    // Expected S/R at offset k from the accepting cycle (k=0 is the accept cycle)
    function automatic logic [W-1:0] exp_s(int k, logic [W-1:0] o, logic [W-1:0] n);
        if (k == 0) return o;
        if (k <= D) return o & n;
        return n;
    endfunction

    function automatic logic [W-1:0] exp_r(int k, logic [W-1:0] o, logic [W-1:0] n);
        if (k == 0) return ~o;
        if (k <= D) return ~o & ~n;
        return ~n;
    endfunction

    task automatic record(input int k);
        o_s[k] = s; o_r[k] = r; o_app[k] = applied; o_err[k] = err_mask;
        o_rdy[k] = tgt.tgt_ready; o_done[k] = done; o_busy[k] = busy;
    endtask

    // Offers d at the current negedge and records offsets 0..6
    task automatic xfer(input logic [W-1:0] d);
        tgt.tgt_valid = 1'b1;
        tgt.tgt_data  = d;
        record(0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) tgt.tgt_valid = 1'b0;
            record(k);
        end
    endtask

    task automatic test_reset();
        tgt.tgt_valid = 1'b1;
        tgt.tgt_data  = 4'($urandom_range(1, 15));
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        checks++; if (tgt.tgt_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", tgt.tgt_ready); end
        checks++; if (applied !== 4'b0000) begin errors++; $display("FAIL rst_applied got %b exp 0000", applied); end
        rst = 1'b0;
        tgt.tgt_valid = 1'b0;
        @(negedge clk);
        checks++; if (s !== 4'b0000) begin errors++; $display("FAIL idle_s got %b exp 0000", s); end
        checks++; if (r !== 4'b1111) begin errors++; $display("FAIL idle_r got %b exp 1111", r); end
        checks++; if (tgt.tgt_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", tgt.tgt_ready); end
        checks++; if (applied !== 4'b0000) begin errors++; $display("FAIL idle_applied got %b exp 0000", applied); end
        checks++; if (err_mask !== 4'b0000) begin errors++; $display("FAIL idle_err got %b exp 0000", err_mask); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_done_busy got %b%b exp 00", done, busy); end
        cur_app = '0;
        cur_err = '0;
    endtask

    task automatic test_basic();
        logic [W-1:0] n;
        n = 4'b1010;
        xfer(n);
        for (int k = 0; k <= 6; k++) begin
            checks++; if (o_s[k] !== exp_s(k, cur_app, n)) begin errors++; $display("FAIL basic_s k=%0d got %b exp %b", k, o_s[k], exp_s(k, cur_app, n)); end
            checks++; if (o_r[k] !== exp_r(k, cur_app, n)) begin errors++; $display("FAIL basic_r k=%0d got %b exp %b", k, o_r[k], exp_r(k, cur_app, n)); end
            checks++; if (o_done[k] !== (k == LAT)) begin errors++; $display("FAIL basic_done k=%0d got %b exp %b", k, o_done[k], (k == LAT)); end
            checks++; if (o_rdy[k] !== (k == 0 || k >= LAT)) begin errors++; $display("FAIL basic_ready k=%0d got %b exp %b", k, o_rdy[k], (k == 0 || k >= LAT)); end
        end
        checks++; if (o_app[LAT] !== n) begin errors++; $display("FAIL basic_applied got %b exp %b", o_app[LAT], n); end
        checks++; if (o_err[LAT] !== 4'b0000) begin errors++; $display("FAIL basic_err got %b exp 0000", o_err[LAT]); end
        cur_app = n;
    endtask

    task automatic test_nochange();
        xfer(cur_app);
        for (int k = 0; k <= 6; k++) begin
            checks++; if (o_s[k] !== cur_app || o_r[k] !== ~cur_app) begin errors++; $display("FAIL nochg_sr k=%0d got %b/%b exp %b/%b", k, o_s[k], o_r[k], cur_app, ~cur_app); end
            checks++; if (o_done[k] !== (k == LAT)) begin errors++; $display("FAIL nochg_done k=%0d got %b exp %b", k, o_done[k], (k == LAT)); end
        end
        checks++; if (o_err[LAT] !== 4'b0000) begin errors++; $display("FAIL nochg_err got %b exp 0000", o_err[LAT]); end
    endtask

    task automatic test_stuck();
        stuck_mask = 4'b0100;
        stuck_val  = 4'b0100;
        xfer(4'b0000);
        checks++; if (o_done[LAT] !== 1'b1) begin errors++; $display("FAIL stuck_done got %b exp 1", o_done[LAT]); end
        checks++; if (o_err[LAT - 1] !== 4'b0000) begin errors++; $display("FAIL stuck_err_early got %b exp 0000", o_err[LAT - 1]); end
        checks++; if (o_err[LAT] !== 4'b0100) begin errors++; $display("FAIL stuck_err got %b exp 0100", o_err[LAT]); end
        checks++; if (o_err[6] !== 4'b0100) begin errors++; $display("FAIL stuck_err_hold got %b exp 0100", o_err[6]); end
        stuck_mask = '0;
        cur_app = 4'b0000;
        cur_err = 4'b0100;
    endtask

    task automatic test_reset_mid();
        tgt.tgt_valid = 1'b1;
        tgt.tgt_data  = 4'b0110;
        @(negedge clk);
        tgt.tgt_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tgt.tgt_valid = 1'b1;
        tgt.tgt_data  = 4'b1111;
        @(negedge clk);
        checks++; if (s !== 4'b0000 || r !== 4'b1111) begin errors++; $display("FAIL midrst_sr got %b/%b exp 0000/1111", s, r); end
        checks++; if (applied !== 4'b0000) begin errors++; $display("FAIL midrst_applied got %b exp 0000", applied); end
        checks++; if (err_mask !== 4'b0000) begin errors++; $display("FAIL midrst_err got %b exp 0000", err_mask); end
        checks++; if (busy !== 1'b0 || tgt.tgt_ready !== 1'b0) begin errors++; $display("FAIL midrst_busy_ready got %b%b exp 00", busy, tgt.tgt_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || applied !== 4'b0000) begin errors++; $display("FAIL midrst_nodone got %b/%b exp 0/0000", done, applied); end
        rst = 1'b0;
        tgt.tgt_valid = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || applied !== 4'b0000 || tgt.tgt_ready !== 1'b1) begin errors++; $display("FAIL midrst_after got %b/%b/%b exp 0/0000/1", done, applied, tgt.tgt_ready); end
        cur_app = '0;
        cur_err = '0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic         exp_rdy;
        a = 4'($urandom_range(0, 15));
        b = ~a;
        tgt.tgt_valid = 1'b1;
        tgt.tgt_data  = a;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_rdy = (k == 4 || k == 8);
            checks++; if (tgt.tgt_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, tgt.tgt_ready, exp_rdy); end
            checks++; if (done !== (k == 4 || k == 8)) begin errors++; $display("FAIL b2b_done k=%0d got %b exp %b", k, done, (k == 4 || k == 8)); end
            checks++; if (applied !== ((k <= 4) ? a : b)) begin errors++; $display("FAIL b2b_applied k=%0d got %b exp %b", k, applied, (k <= 4) ? a : b); end
            if (k == 5) begin
                checks++; if (s !== (a & b) || r !== (~a & ~b)) begin errors++; $display("FAIL b2b_dead got %b/%b exp %b/%b", s, r, a & b, ~a & ~b); end
                tgt.tgt_valid = 1'b0;
            end
            if (k == 1) tgt.tgt_data = b;
        end
        cur_app = b;
    endtask

    task automatic test_random();
        logic [W-1:0] n, e_err;
        int           gap;
        for (int it = 0; it < 25; it++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++; if (s !== cur_app || r !== ~cur_app || tgt.tgt_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rnd_idle got %b/%b/%b/%b exp %b/%b/1/0", s, r, tgt.tgt_ready, done, cur_app, ~cur_app); end
            end
            if ($urandom_range(0, 3) == 0) begin
                stuck_mask = 4'($urandom_range(0, 15));
                stuck_val  = 4'($urandom_range(0, 15));
            end else begin
                stuck_mask = '0;
            end
            n = 4'($urandom_range(0, 15));
            e_err = stuck_mask & (stuck_val ^ n);
            xfer(n);
            for (int k = 0; k <= 6; k++) begin
                checks++; if (o_s[k] !== exp_s(k, cur_app, n) || o_r[k] !== exp_r(k, cur_app, n)) begin errors++; $display("FAIL rnd_sr it=%0d k=%0d got %b/%b exp %b/%b", it, k, o_s[k], o_r[k], exp_s(k, cur_app, n), exp_r(k, cur_app, n)); end
                checks++; if (o_done[k] !== (k == LAT) || o_busy[k] !== (k >= 1 && k < LAT)) begin errors++; $display("FAIL rnd_ctl it=%0d k=%0d got %b%b exp %b%b", it, k, o_done[k], o_busy[k], (k == LAT), (k >= 1 && k < LAT)); end
                checks++; if (o_err[k] !== ((k >= LAT) ? e_err : cur_err)) begin errors++; $display("FAIL rnd_err it=%0d k=%0d got %b exp %b", it, k, o_err[k], (k >= LAT) ? e_err : cur_err); end
                checks++; if (o_app[k] !== ((k >= 1) ? n : cur_app)) begin errors++; $display("FAIL rnd_applied it=%0d k=%0d got %b exp %b", it, k, o_app[k], (k >= 1) ? n : cur_app); end
            end
            cur_app = n;
            cur_err = e_err;
        end
        stuck_mask = '0;
    endtask

    task automatic test_invariant();
        checks++;
        if (inv_viol !== 0) begin errors++; $display("FAIL sr_invariant got %0d cycles with s&r!=0 exp 0", inv_viol); end
    endtask

    initial begin
        tgt.tgt_valid = 1'b0;
        tgt.tgt_data  = '0;
        test_reset();
        test_basic();
        test_nochange();
        test_stuck();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_invariant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/sr_bank_driver.md
Name: sr_bank_driver

Overview:
- Controller that drives the S/R inputs of a bank of WIDTH team SR flip-flops (sr_ff semantics: S/R=10 → q=1, 01 or 00 → q=0, 11 forbidden) and reads back their q/q_bar.
- Accepts a target bit-vector over a valid/ready handshake.
- Sequences a dead phase, a drive phase and a settle phase, checks the feedback, then reports done plus a per-bit error mask.
- Sits between register-write logic and flop-bank macros.

Parameters:
- WIDTH, 8: number of flops driven.
- DEAD_CYCLES, 1: cycles of S/R=00 applied to changing bits before the new value; 0 skips the dead phase.
- SETTLE_CYCLES, 2: cycles the target encoding is driven before q_fb is sampled; must be ≥2 (one cycle of flop latency plus one sample cycle).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- tgt_valid  in  1  target vector offered.
- tgt_data  in  WIDTH  requested flop values.
- tgt_ready  out  1  high only in IDLE.
- s  out  WIDTH  set lines to the flops (registered).
- r  out  WIDTH  reset lines to the flops (registered).
- q_fb  in  WIDTH  flop q readback.
- qb_fb  in  WIDTH  flop q_bar readback.
- applied  out  WIDTH  last accepted target.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- err_mask  out  WIDTH  bit i = 1 if q_fb[i]≠applied[i] or qb_fb[i]≠~applied[i] at sample time.

Behaviour:
- Reset values (effective the cycle after rst is sampled high):
  - state=IDLE, applied=0, s=0, r=all-ones (flops driven to 0).
  - done=0, err_mask=0, busy=0.
- While rst is high: tgt_ready=0 and tgt_valid is ignored.
- Invariant: s[i]&r[i]==0 for every bit in every cycle, including reset and state transitions.
- IDLE:
  - tgt_ready=1; s=applied, r=~applied (continuous drive, because the flops have no hold code).
  - Accept when tgt_valid&tgt_ready at the edge ending cycle T; latch tgt_data into applied and into a change mask (new XOR old).
- DEAD (cycles T+1 .. T+DEAD_CYCLES):
  - Changed bits drive s=0, r=0.
  - Unchanged bits keep their old encoding.
  - The phase occurs even when the change mask is 0, so latency is fixed.
- DRIVE/SETTLE (next SETTLE_CYCLES cycles): all bits drive s=applied, r=~applied.
- CHECK: at the end of the last settle cycle, sample q_fb and qb_fb and compute err_mask.
- Completion (cycle T+1+DEAD_CYCLES+SETTLE_CYCLES):
  - State is IDLE, done=1 for exactly this cycle, err_mask updated.
  - tgt_ready=1 in the same cycle, so a back-to-back accept is allowed.
- err_mask holds until the next completion; it is cleared only by reset.
- Defaults (DEAD_CYCLES=1, SETTLE_CYCLES=2): accept at T gives dead pattern at T+1, target at T+2..T+3, sample at end of T+3, done at T+4.
- tgt_valid while busy: ignored; tgt_data must be held by the source until accepted.
- Reset mid-operation: sequence aborted, no done pulse, all reset values apply next cycle.
- Phase timer width is clog2(max(DEAD_CYCLES,SETTLE_CYCLES)+1). It counts down, loads on phase entry and never wraps.

Decomposition:
- Package sr_drv_pkg:
  - state enum {IDLE, DEAD, SETTLE}.
  - Localparams for the S/R encodings: SR_SET=2'b10, SR_CLR=2'b01, SR_DEAD=2'b00.
  - Function encode(bit) returning {s,r}.
- One sub-module: sr_phase_timer. Loadable down-counter with a zero flag, used for both the DEAD and SETTLE phases.

Test Plan (WIDTH=4, defaults, sr_ff bank model on feedback):
- Reset then idle → s=4'b0000, r=4'b1111, tgt_ready=1, applied=0, err_mask=0, no done.
- Accept tgt_data=4'b1010 at T →
  - T+1: s=0000, r=0101 (bits 1,3 dead).
  - T+2: s=1010, r=0101.
  - T+4: done=1, err_mask=0000, applied=1010.
- Accept 4'b1010 again (no change) → s/r constant throughout, done at T+4, err_mask=0.
- Force model bit 2 stuck at 1, target 4'b0000 → done at T+4 with err_mask=4'b0100.
- Assert rst at T+2 of a transfer → no done; next cycle s=0, r=1111, applied=0; tgt_valid held during reset is not accepted.
- Back-to-back: keep tgt_valid high with a new value at the done cycle → accepted there, tgt_ready low for the next 3 cycles, second done 4 cycles later. Assertion s&r==0 never fires across the run.
